// File: rtl/cdc_import_fifo.sv
// Destination-side endpoint of a req/ack toggle CDC handshake.
// Incoming words land in a small FWFT FIFO; backpressure reaches the source by withholding ack.
module cdc_import_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           cdc_data,
  input  logic                       cdc_req,
  output logic                       cdc_ack,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("cdc_import_fifo: DEPTH must be a power of two >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("cdc_import_fifo: SYNC_STAGES must be >= 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] r_sync;
  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [LW-1:0]          r_level;
  logic                   r_ack;
  logic                   w_req_s, w_pending, w_full, w_push, w_pop;

  // Only this chain ever samples the asynchronous req input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], cdc_req};
  end

  assign w_req_s   = r_sync[SYNC_STAGES-1];
  assign w_pending = (w_req_s != r_ack);
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_pop     = out_valid && out_ready;
  // A pop frees a slot on the same edge, so a full FIFO can still accept.
  assign w_push    = w_pending && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ack   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= cdc_data;
        r_wptr        <= r_wptr + AW'(1);
        r_ack         <= w_req_s;
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  assign cdc_ack   = r_ack;
  assign out_data  = r_mem[r_rptr];
  assign out_valid = (r_level != '0);
  assign level     = r_level;

endmodule

// File: tb/tb_cdc_import_fifo.sv
// Randomized scoreboard bench for cdc_import_fifo: queue-based reference model,
// per-cycle level/valid/ack comparison and in-order data checking.
module tb_cdc_import_fifo;
  localparam int W = 8, D = 4, S = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [W-1:0] cdc_data;
  logic cdc_req, cdc_ack;
  logic [W-1:0] out_data;
  logic out_valid, out_ready;
  logic [$clog2(D+1)-1:0] level;

  logic [31:0] d2_data, d2_odata;
  logic d2_req, d2_ack, d2_ovalid, d2_ready;
  logic [3:0] d2_level;

  always #5 clk = ~clk;

  cdc_import_fifo #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .cdc_data(cdc_data), .cdc_req(cdc_req), .cdc_ack(cdc_ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .level(level)
  );

  cdc_import_fifo #(.WIDTH(32), .DEPTH(8), .SYNC_STAGES(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .cdc_data(d2_data), .cdc_req(d2_req), .cdc_ack(d2_ack),
    .out_data(d2_odata), .out_valid(d2_ovalid), .out_ready(d2_ready), .level(d2_level)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // reference model state
  int   mlevel;
  logic mack;
  logic hist[$];   // hist[k] = cdc_req sampled k+1 edges ago

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mlevel = 0;
    mack   = 1'b0;
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_back(1'b0);
  endtask

  // The word handed over by the source is seen by the FIFO S edges later;
  // it moves in when there is room or a word leaves on the same edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        logic pop_m, push_m, seen;
        seen   = hist[S-1];
        pop_m  = (mlevel != 0) && out_ready;
        push_m = (seen != mack) && (mlevel < D || pop_m);
        if (push_m) mack = seen;
        mlevel = mlevel + int'(push_m) - int'(pop_m);
        hist.push_front(cdc_req);
        void'(hist.pop_back());
      end
    end
  end

  // per-cycle monitor, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("level", 64'(level), 64'(mlevel));
      chk("out_valid", 64'(out_valid), 64'(mlevel != 0));
      chk("cdc_ack", 64'(cdc_ack), 64'(mack));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL data: popped %0h with no word expected", out_data);
        end else chk("data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Source exporter: waits for the previous word to be acknowledged, then toggles req.
  task automatic send(input logic [W-1:0] w);
    int n = 0;
    while (cdc_ack != cdc_req && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL send_timeout: ack %0b req %0b", cdc_ack, cdc_req);
    end
    cdc_data = w;
    cdc_req  = ~cdc_req;
    exp_q.push_back(w);
  endtask

  task automatic wait_drained(input string name, input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < bound) begin tick(); n++; end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    bit sdone;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit sdone;
    rst_n = 1'b0; cdc_data = '0; cdc_req = 1'b0; out_ready = 1'b0;
    d2_data = '0; d2_req = 1'b0; d2_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ack", 64'(cdc_ack), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // single transfer: ack on the third edge after the toggle
    send(8'hA5);
    n = 0;
    while (cdc_ack != 1'b1 && n < 20) begin tick(); n++; end
    chk("single_latency", 64'(n), 64'd3);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data), 64'hA5);
    chk("single_level", 64'(level), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("single_popped_valid", 64'(out_valid), 64'd0);
    chk("single_popped_level", 64'(level), 64'd0);
    out_ready = 1'b0;
    repeat (2) tick();

    // burst into a stalled consumer
    for (int i = 1; i <= 5; i++) send(W'(i));
    repeat (10) tick();
    chk("burst_level", 64'(level), 64'd4);
    chk("burst_stalled", 64'(cdc_ack != cdc_req), 64'd1);
    out_ready = 1'b1;
    n = 0;
    while ((level != 0 || out_valid) && n < 30) begin tick(); n++; end
    chk("drain_cycles", 64'(n), 64'd5);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b0;
    repeat (2) tick();

    // wrap-around with a randomly stalling consumer
    sdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(W'($urandom_range(0, 255)));
        sdone = 1'b1;
      end
      begin
        for (int c = 0; c < 600; c++) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
          if (sdone && exp_q.size() == 0 && !out_valid) break;
        end
      end
    join
    out_ready = 1'b0;
    chk("wrap_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) tick();

    // reset with three words held and req left high
    for (int i = 0; i < 3; i++) send(W'($urandom_range(0, 255)));
    n = 0;
    while ((level != 3 || cdc_ack != cdc_req) && n < 40) begin tick(); n++; end
    chk("pre_reset_level", 64'(level), 64'd3);
    chk("pre_reset_req", 64'(cdc_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_ack", 64'(cdc_ack), 64'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    if (cdc_req) exp_q.push_back(cdc_data);
    n = 0;
    while (cdc_ack != cdc_req && n < 20) begin tick(); n++; end
    chk("post_reset_latency", 64'(n), 64'd3);
    chk("post_reset_data", 64'(out_data), 64'(cdc_data));
    out_ready = 1'b1;
    wait_drained("post_reset_drain", 20);
    out_ready = 1'b0;
    repeat (2) tick();

    // wider/deeper instance with a 3-flop synchroniser
    d2_data = 32'hDEADBEEF;
    d2_req  = 1'b1;
    n = 0;
    while (d2_ack != 1'b1 && n < 20) begin tick(); n++; end
    chk("sweep_latency", 64'(n), 64'd4);
    chk("sweep_data", 64'(d2_odata), 64'hDEADBEEF);
    chk("sweep_level", 64'(d2_level), 64'd1);
    chk("sweep_valid", 64'(d2_ovalid), 64'd1);
    d2_ready = 1'b1;
    tick();
    chk("sweep_popped", 64'(d2_level), 64'd0);
    d2_ready = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_import_fifo.md
Name: cdc_import_fifo

Overview:
- Destination-side endpoint of the req/ack toggle handshake used for clock-domain crossing.
- Generalised successor to the single-word importer:
  - configurable data width and synchroniser depth;
  - a local FIFO of DEPTH words;
  - valid/ready output stream with backpressure propagated back across the domain boundary by withholding ack;
  - asynchronous active-low reset.
- Sits in the receiving clock domain. Connects to a source-side exporter running on a foreign clock.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 4: FIFO entries. Power of two, >= 2.
- SYNC_STAGES, 2: flops in the req synchroniser, >= 2.

Ports:
- clk  in  1  destination-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- cdc_data  in  WIDTH  word from the source domain; stable while cdc_req != cdc_ack.
- cdc_req  in  1  toggle from the source domain; asynchronous to clk.
- cdc_ack  out  1  toggle returned to the source; registered.
- out_data  out  WIDTH  FIFO head word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts the head word this cycle.
- level  out  $clog2(DEPTH+1)  number of words currently held.

Behaviour:
- Reset: one clock (clk) domain; reset asynchronous, active-low on rst_n. While rst_n=0:
  - all synchroniser flops = 0, cdc_ack = 0;
  - FIFO empty: out_valid = 0, level = 0, out_data = 0;
  - read/write pointers = 0.
- Synchroniser:
  - cdc_req passes through a SYNC_STAGES-deep flop chain; req_s is the last stage.
  - No logic other than the chain samples cdc_req.
- Pending condition: pending = (req_s != cdc_ack).
- Push: happens when pending and (level < DEPTH, or a pop occurs the same cycle). On that edge:
  - cdc_data is written at the write pointer;
  - the write pointer increments modulo DEPTH;
  - cdc_ack <= req_s.
- Latency:
  - A req toggle sampled at edge 1 reaches req_s at edge SYNC_STAGES and is pushed at edge SYNC_STAGES+1.
  - out_valid rises after that edge if the FIFO was empty.
  - cdc_ack toggles on the same edge as the push.
- Pop:
  - happens when out_valid && out_ready;
  - the read pointer increments modulo DEPTH.
  - out_data is combinational from the head entry (first-word fall-through).
  - out_ready while out_valid=0 is ignored.
- Level:
  - level += push - pop each cycle;
  - out_valid = (level != 0).
  - Simultaneous push and pop leaves level unchanged.
- Full (level == DEPTH):
  - no push and cdc_ack is held, which stalls the source;
  - the pending word is taken on the first cycle a pop occurs.
- Loss and duplication:
  - No word is ever dropped or duplicated.
  - At most one push per req toggle, because pending clears on the ack update.
- Pointers:
  - log2(DEPTH) bits, wrapping naturally.
  - Full/empty are decided by level, not by pointer compare.
- Reset mid-operation:
  - FIFO contents are discarded and cdc_ack returns to 0.
  - If cdc_req = 1 at reset release, that is treated as a new pending word after SYNC_STAGES+1 edges.
  - The system resets the source alongside this block.
- Elaboration: DEPTH not a power of two or SYNC_STAGES < 2 is an elaboration error.

Test Plan:
- Reset, then a single transfer: cdc_data=8'hA5, toggle cdc_req 0->1 (SYNC_STAGES=2).
  - Push at edge 3, cdc_ack=1 at edge 3, out_valid=1 after edge 3.
  - out_data=8'hA5, level=1.
  - With out_ready=1: out_valid=0 after the next edge, level=0.
- Burst with no consumer: out_ready=0, source sends 8'h01..8'h05 with DEPTH=4.
  - level reaches 4; cdc_ack stops after the 4th toggle; 5th word pending.
- Drain after the burst: raise out_ready.
  - Outputs 01,02,03,04,05 in order, one per cycle after 05 is captured.
  - 05 is pushed on the same edge as the first pop; level never exceeds 4.
- Wrap-around: send 10 words with out_ready toggling pseudo-randomly.
  - Output sequence equals input sequence with no loss or duplicates.
  - level matches the model every cycle.
- Reset mid-operation: with level=3 and cdc_req=1, pulse rst_n low for 1 cycle.
  - Immediately: out_valid=0, level=0, cdc_ack=0.
  - After release, the cdc_req=1 mismatch is pushed at edge 3.
- Parameter sweep: WIDTH=32, DEPTH=8, SYNC_STAGES=3, single word 32'hDEADBEEF.
  - Push occurs 4 edges after the req toggle; out_data=32'hDEADBEEF.
